// File: rtl/led_pattern_pkg.sv
// Shared types and default parameters for the LED test-pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_WALK    = 2'd1,
        MODE_STATIC  = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIV_W = 25;
    localparam int DEF_PWM_W = 8;

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// Saturating prescaler: one-cycle tick every div_i clocks (0 and 1 mean every clock).
// Shrinking div_i below the current count ticks on the very next compare, never overruns.
module tick_divider
    import led_pattern_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt_r;
    logic [DIV_W-1:0] last_s;

    // Terminal count, with 0 and 1 both collapsing to "every cycle".
    always_comb begin
        last_s = {DIV_W{1'b0}};
        if (div_i <= DIV_W'(1)) begin
            last_s = {DIV_W{1'b0}};
        end else begin
            last_s = div_i - DIV_W'(1);
        end
    end

    assign tick = (pcnt_r >= last_s);

    // Prescaler counter, cleared on every tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt_r <= {DIV_W{1'b0}};
        end else if (tick) begin
            pcnt_r <= {DIV_W{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED test-pattern generator: COUNT, WALK, STATIC and (with LED_PATTERN_BREATHE_EN
// defined) PWM BREATHE; without that macro mode 3 shows the static image.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W,
    parameter int PWM_W = DEF_PWM_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             dir_i,
    input  logic             pause_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] static_i,
    output logic [WIDTH-1:0] leds_o,
    output logic             tick_o,
    output logic             wrap_o
);

    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || PWM_W < 1) begin : g_param_check
        $error("led_pattern_gen: WIDTH and PWM_W must be at least 1");
    end

    logic             tick_s;
    logic             rise_s;
    logic             mode_chg_s;
    logic             adv_s;
    logic             wrap_s;
    logic [WIDTH-1:0] pattern_s;

    logic             step_q_r;
    led_mode_e        mode_q_r;
    logic [WIDTH-1:0] cnt_r;
    logic [POS_W-1:0] pos_r;
    logic             walk_up_r;
    logic [WIDTH-1:0] leds_r;
    logic             tick_r;
    logic             wrap_r;

    tick_divider #(.DIV_W(DIV_W)) u_tick_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .div_i   (div_i),
        .tick    (tick_s)
    );

    assign rise_s     = step_i & ~step_q_r;
    assign mode_chg_s = (mode_i != mode_q_r);
    // A mode switch swallows any advance that lands in the same cycle.
    assign adv_s      = ((tick_s & ~pause_i) | (pause_i & rise_s)) & ~mode_chg_s;

`ifdef LED_PATTERN_BREATHE_EN
    localparam logic [PWM_W-1:0] LVL_MAX = {PWM_W{1'b1}};

    logic [PWM_W-1:0] lvl_r;
    logic             lvl_up_r;
    logic [PWM_W-1:0] pwm_r;

    // Triangle brightness level plus free-running PWM compare counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lvl_r    <= {PWM_W{1'b0}};
            lvl_up_r <= 1'b1;
            pwm_r    <= {PWM_W{1'b0}};
        end else begin
            pwm_r <= pwm_r + PWM_W'(1);
            if (mode_chg_s) begin
                lvl_r    <= {PWM_W{1'b0}};
                lvl_up_r <= 1'b1;
            end else if (adv_s && (mode_q_r == MODE_BREATHE)) begin
                if (lvl_up_r) begin
                    lvl_r <= lvl_r + PWM_W'(1);
                    if (lvl_r == (LVL_MAX - PWM_W'(1))) begin
                        lvl_up_r <= 1'b0;
                    end
                end else begin
                    lvl_r <= lvl_r - PWM_W'(1);
                    if (lvl_r == PWM_W'(1)) begin
                        lvl_up_r <= 1'b1;
                    end
                end
            end
        end
    end
`endif

    // Wrap condition evaluated on the pre-advance state of the active pattern.
    always_comb begin
        wrap_s = 1'b0;
        if (adv_s) begin
            case (mode_q_r)
                MODE_COUNT: wrap_s = dir_i ? (cnt_r == {WIDTH{1'b0}})
                                           : (cnt_r == {WIDTH{1'b1}});
                MODE_WALK:  wrap_s = (WIDTH == 1) ? 1'b1
                                   : (!walk_up_r && (pos_r == POS_W'(1)));
`ifdef LED_PATTERN_BREATHE_EN
                MODE_BREATHE: wrap_s = !lvl_up_r && (lvl_r == PWM_W'(1));
`endif
                default:    wrap_s = 1'b0;
            endcase
        end else begin
            wrap_s = 1'b0;
        end
    end

    // LED image for the current pattern state.
    always_comb begin
        pattern_s = {WIDTH{1'b0}};
        case (mode_q_r)
            MODE_COUNT:   pattern_s = cnt_r;
            MODE_WALK:    pattern_s = WIDTH'(1) << pos_r;
            MODE_STATIC:  pattern_s = static_i;
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: pattern_s = {WIDTH{(pwm_r < lvl_r)}};
`endif
            default:      pattern_s = static_i;
        endcase
    end

    // Mode tracking, counter/walker state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step_q_r  <= 1'b0;
            mode_q_r  <= led_mode_e'(mode_i);
            cnt_r     <= WIDTH'(1);
            pos_r     <= {POS_W{1'b0}};
            walk_up_r <= 1'b1;
            leds_r    <= {WIDTH{1'b0}};
            tick_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            step_q_r <= step_i;
            mode_q_r <= led_mode_e'(mode_i);
            tick_r   <= tick_s;
            wrap_r   <= wrap_s;
            leds_r   <= pattern_s;
            if (mode_chg_s) begin
                cnt_r     <= WIDTH'(1);
                pos_r     <= {POS_W{1'b0}};
                walk_up_r <= 1'b1;
            end else if (adv_s) begin
                case (mode_q_r)
                    MODE_COUNT: cnt_r <= dir_i ? (cnt_r - WIDTH'(1)) : (cnt_r + WIDTH'(1));
                    MODE_WALK: begin
                        // Direction flips on arrival at either end so there is no dwell.
                        if (WIDTH > 1) begin
                            if (walk_up_r) begin
                                pos_r <= pos_r + POS_W'(1);
                                if (pos_r == POS_W'(WIDTH - 2)) begin
                                    walk_up_r <= 1'b0;
                                end
                            end else begin
                                pos_r <= pos_r - POS_W'(1);
                                if (pos_r == POS_W'(1)) begin
                                    walk_up_r <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign leds_o = leds_r;
    assign tick_o = tick_r;
    assign wrap_o = wrap_r;

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED test-pattern generator for the board top level: a programmable prescaler advances one of several display patterns (binary counter, bouncing walker, static switch image, optional PWM breathing) onto an LED bank of configurable width. It replaces the fixed free-running counter tap and adds mode select, direction, pause and single-step. The block is instantiated in the top level on the 25 MHz clock, driving LEDG or LEDR from SW and KEY.

## Interface
Parameters:
- WIDTH, 8: number of LED outputs (≥1).
- DIV_W, 25: prescaler counter width.
- PWM_W, 8: brightness/PWM resolution (breathe mode only).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- mode_i  in  2  0=COUNT, 1=WALK, 2=STATIC, 3=BREATHE.
- div_i  in  DIV_W  prescaler period in clk cycles; 0 and 1 both mean every cycle.
- dir_i  in  1  COUNT: 0 up, 1 down; ignored in other modes.
- pause_i  in  1  freezes pattern advance.
- step_i  in  1  level input; each rising edge gives one advance while paused.
- static_i  in  WIDTH  pattern shown in STATIC mode.
- leds_o  out  WIDTH  registered LED drive.
- tick_o  out  1  one-cycle prescaler tick pulse, independent of pause.
- wrap_o  out  1  one-cycle pulse when the pattern completes a cycle.

## Operation
- Prescaler: pcnt counts 0..div_i−1. tick is asserted when pcnt ≥ div_i−1 (saturating compare), and pcnt returns to 0 on that cycle. A shrunk div_i therefore ticks on the next cycle and never overruns.
- Step edge: step_q <= step_i. rise = step_i & ~step_q.
- adv = (tick & ~pause_i) | (pause_i & rise). A rise while not paused is ignored.
- mode_q registers mode_i. When mode_i ≠ mode_q, the new mode's state is reinitialised in that cycle and adv is suppressed.
- COUNT:
  - cnt ± 1 per adv, modulo 2^WIDTH.
  - wrap_o on all-ones→0 (up) or 0→all-ones (down).
  - Initial cnt = 1.
- WALK:
  - One-hot position pos plus direction flag. Initial state is pos=0, moving up.
  - At pos=WIDTH−1 the flag flips and the next adv moves down. At pos=0 the flag flips back.
  - No dwell at the ends: the sequence for WIDTH=4 is 0,1,2,3,2,1,0,1…
  - wrap_o when arriving at pos 0 from above.
  - WIDTH=1: pos stays 0, and wrap_o pulses on every adv.
- STATIC: leds = static_i, passed through every cycle. adv has no effect, and wrap_o stays 0.
- BREATHE:
  - Level lvl ramps 0→2^PWM_W−1→0 by ±1 per adv (triangle wave).
  - A free-running pwm counter increments every clk.
  - Every LED shows (pwm < lvl).
  - wrap_o when lvl returns to 0.
- tick_o pulses regardless of mode and pause.

## Timing
- Reset (reset_n=0 at an edge):
  - pcnt=0, step_q=0, mode_q=mode_i, cnt=1, pos=0 moving up, lvl=0, pwm=0.
  - leds_o=0, tick_o=0, wrap_o=0.
- Pattern state updates at the edge where adv=1. leds_o is registered from the updated state one edge later, giving a 2-cycle latency from tick to LED change.
- STATIC: static_i reaches leds_o after 1 cycle.
- tick_o and wrap_o are registered and align with the state update edge (latency 1 from the prescaler compare).
- Reset asserted mid-operation overrides everything in the same edge. No pulse is emitted during reset.
- A mode change and a tick in the same cycle: reinit wins, and the tick is lost for pattern purposes.
- After a mode change, the first cycle of the new pattern appears on leds_o 2 edges after mode_i changes.

## Configuration
- LED_PATTERN_BREATHE_EN defined: BREATHE mode, the lvl and pwm registers and the PWM_W logic are compiled in.
- LED_PATTERN_BREATHE_EN undefined: mode 3 behaves exactly as STATIC, and no PWM registers exist.

## Structure
- led_pattern_pkg holds:
  - enum led_mode_e {MODE_COUNT, MODE_WALK, MODE_STATIC, MODE_BREATHE} (2 bits).
  - localparam defaults for WIDTH/DIV_W/PWM_W.
- Sub-module tick_divider (clk, reset_n, div_i → tick) contains the saturating prescaler. It is reusable by the top level for other slow strobes.

## Test plan
- Reset, COUNT, div_i=4, dir_i=0: tick_o every 4th cycle; leds_o shows 1,2,3…; with WIDTH=4, wrap_o pulses on 15→0.
- COUNT, dir_i=1 from cnt=1, div_i=1: leds_o 1,0,15,14; wrap_o on 0→15.
- WALK, WIDTH=4, div_i=1: leds_o 0001,0010,0100,1000,0100,0010,0001; wrap_o on the return to 0001.
- pause_i=1 with three step_i rising edges separated by 10 cycles, plus ticks ongoing: exactly 3 advances. step_i held high yields 1 advance.
- div_i changed 100→3 while pcnt=50: tick on the next cycle, then every 3 cycles. Mode changed COUNT→WALK mid-count: leds_o returns to 0001, and no adv occurs that cycle.
- With LED_PATTERN_BREATHE_EN, PWM_W=2, div_i=1: lvl 0,1,2,3,2,1,0; at lvl=2, LEDs are high 2 of every 4 cycles. Without the macro, mode 3 gives leds_o=static_i.
